// File: rtl/keypad_pkg.sv
// Shared key codes, key classification and FSM state type for the keypad entry block.
package keypad_pkg;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef enum logic {
    S_RELEASED = 1'b0,
    S_PRESSED  = 1'b1
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= KEY_9);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces a W-bit scanner code; codes C..E are folded to F (none) before any comparison.
// The stable output already reflects the sample being taken this cycle, so downstream logic
// acting on it in the same edge sees a new key exactly DEBOUNCE en-cycles after it first appears.
module key_debounce #(
  parameter int W        = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] stable
);

  localparam logic [4:0]   DEB       = 5'(DEBOUNCE);
  localparam logic [W-1:0] CODE_NONE = '1;
  localparam logic [W-1:0] CODE_C    = W'(12);

  logic [W-1:0] w_din;
  logic [W-1:0] r_cand;
  logic [W-1:0] r_stable;
  logic [4:0]   r_cnt;
  logic [4:0]   w_run;
  logic         w_hit;

  always_comb begin
    w_din = din;
    if ((din >= CODE_C) && (din != CODE_NONE)) w_din = CODE_NONE;
    w_run  = (w_din == r_cand) ? (r_cnt + 5'd1) : 5'd1;
    w_hit  = en && (w_run >= DEB);
    stable = w_hit ? w_din : r_stable;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand   <= CODE_NONE;
      r_cnt    <= 5'd0;
      r_stable <= CODE_NONE;
    end else if (en) begin
      r_cand <= w_din;
      r_cnt  <= (w_run > DEB) ? DEB : w_run;
      if (w_hit) r_stable <= w_din;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry: debounced press detection, BCD entry buffer, '#' commit and '*' edit.
// KEYPAD_ENTRY_BACKSPACE_EN selects '*' = delete newest digit; otherwise '*' clears the buffer.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [3:0]          key,
  output logic [4*DIGITS-1:0] buf_digits,
  output logic [3:0]          buf_count,
  output logic [4*DIGITS-1:0] value,
  output logic [3:0]          value_count,
  output logic                value_valid,
  output logic                overflow,
  output logic [3:0]          press_code
);

  localparam int         BUF_W   = 4 * DIGITS;
  localparam logic [3:0] CNT_MAX = 4'(DIGITS);

  logic [3:0]       w_stable;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_press;
  logic [BUF_W-1:0] r_buf;
  logic [3:0]       r_count;
  logic [BUF_W-1:0] r_value;
  logic [3:0]       r_vcount;
  logic             r_valid;
  logic             r_ovf;
  logic [3:0]       r_press_code;

  key_debounce #(
    .W        (4),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .din    (key),
    .stable (w_stable)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RELEASED;
    else     r_state <= w_state_nxt;
  end

  // One press event per key-down; a different code while held is ignored until release.
  always_comb begin
    w_state_nxt = r_state;
    w_press     = 1'b0;
    if (en) begin
      case (r_state)
        S_RELEASED: begin
          if (w_stable != KEY_NONE) begin
            w_press     = 1'b1;
            w_state_nxt = S_PRESSED;
          end
        end
        S_PRESSED: begin
          if (w_stable == KEY_NONE) w_state_nxt = S_RELEASED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf        <= '0;
      r_count      <= 4'd0;
      r_value      <= '0;
      r_vcount     <= 4'd0;
      r_valid      <= 1'b0;
      r_ovf        <= 1'b0;
      r_press_code <= KEY_NONE;
    end else begin
      r_valid <= 1'b0;
      if (w_press) begin
        r_press_code <= w_stable;
        if (is_digit(w_stable)) begin
          if (r_count < CNT_MAX) begin
            r_buf   <= (r_buf << 4) | BUF_W'(w_stable);
            r_count <= r_count + 4'd1;
          end else begin
            r_ovf <= 1'b1;
          end
        end else if (w_stable == KEY_HASH) begin
          r_value  <= r_buf;
          r_vcount <= r_count;
          r_valid  <= 1'b1;
          r_buf    <= '0;
          r_count  <= 4'd0;
          r_ovf    <= 1'b0;
        end else if (w_stable == KEY_STAR) begin
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
          if (r_count != 4'd0) begin
            r_buf   <= r_buf >> 4;
            r_count <= r_count - 4'd1;
          end
          r_ovf <= 1'b0;
`else
          r_buf   <= '0;
          r_count <= 4'd0;
          r_ovf   <= 1'b0;
`endif
        end
      end
    end
  end

  assign buf_digits  = r_buf;
  assign buf_count   = r_count;
  assign value       = r_value;
  assign value_count = r_vcount;
  assign value_valid = r_valid;
  assign overflow    = r_ovf;
  assign press_code  = r_press_code;

endmodule

// File: tb/tb_keypad_entry.sv
// Randomized bench for keypad_entry against a sample-history / digit-queue reference model.
module tb_keypad_entry;

  localparam int DIGITS   = 4;
  localparam int DEBOUNCE = 3;
  localparam int BW       = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [3:0]    key = 4'hF;
  logic [BW-1:0] buf_digits;
  logic [3:0]    buf_count;
  logic [BW-1:0] value;
  logic [3:0]    value_count;
  logic          value_valid;
  logic          overflow;
  logic [3:0]    press_code;

  keypad_entry #(.DIGITS(DIGITS), .DEBOUNCE(DEBOUNCE)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .key         (key),
    .buf_digits  (buf_digits),
    .buf_count   (buf_count),
    .value       (value),
    .value_count (value_count),
    .value_valid (value_valid),
    .overflow    (overflow),
    .press_code  (press_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          m_hist[$];
  int          m_digits[$];
  int          m_stable;
  bit          m_held;
  int          m_press;
  logic [31:0] m_val;
  int          m_vcnt;
  bit          m_vv;
  bit          m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_buf();
    logic [31:0] b = 32'd0;
    foreach (m_digits[i]) b = (b << 4) | 32'(m_digits[i]);
    return b;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_digits.delete();
    m_stable = 15;
    m_held   = 1'b0;
    m_press  = 15;
    m_val    = 32'd0;
    m_vcnt   = 0;
    m_vv     = 1'b0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_act(input int k);
    if (k <= 9) begin
      if (m_digits.size() < DIGITS) m_digits.push_back(k);
      else m_ovf = 1'b1;
    end else if (k == 11) begin
      m_val  = m_buf();
      m_vcnt = m_digits.size();
      m_vv   = 1'b1;
      m_digits.delete();
      m_ovf  = 1'b0;
    end else if (k == 10) begin
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
      if (m_digits.size() > 0) m_digits = m_digits[0:$-1];
`else
      m_digits.delete();
`endif
      m_ovf = 1'b0;
    end
  endtask

  // A code is stable once the last DEBOUNCE samples are all that code.
  task automatic model_sample(input int k);
    int  mk;
    bit  same;
    mk = (k >= 12 && k <= 14) ? 15 : k;
    m_hist.push_back(mk);
    if (m_hist.size() > DEBOUNCE) m_hist = m_hist[1:$];
    if (m_hist.size() == DEBOUNCE) begin
      same = 1'b1;
      foreach (m_hist[i]) if (m_hist[i] != mk) same = 1'b0;
      if (same) m_stable = mk;
    end
    if (!m_held) begin
      if (m_stable != 15) begin
        m_held  = 1'b1;
        m_press = m_stable;
        model_act(m_stable);
      end
    end else if (m_stable == 15) begin
      m_held = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("buf_digits", 32'(buf_digits), m_buf());
    chk("buf_count", 32'(buf_count), 32'(m_digits.size()));
    chk("value", 32'(value), m_val);
    chk("value_count", 32'(value_count), 32'(m_vcnt));
    chk("value_valid", 32'(value_valid), 32'(m_vv));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("press_code", 32'(press_code), 32'(m_press));
  endtask

  task automatic tick(input logic e, input logic [3:0] k);
    en  = e;
    key = k;
    @(posedge clk);
    m_vv = 1'b0;
    if (e) model_sample(int'(k));
    #1;
    check_all();
  endtask

  task automatic hold(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) tick(1'b1, k);
  endtask

  task automatic press(input logic [3:0] k);
    hold(k, DEBOUNCE);
    hold(4'hF, DEBOUNCE);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Single press of 5
    press(4'h5);
    chk("t1_count", 32'(buf_count), 32'd1);
    chk("t1_digit", 32'(buf_digits[3:0]), 32'h5);
    chk("t1_press", 32'(press_code), 32'h5);

    // Glitch shorter than the debounce window
    hold(4'h7, 2);
    hold(4'hF, DEBOUNCE);
    chk("t2_count", 32'(buf_count), 32'd1);
    chk("t2_press", 32'(press_code), 32'h5);
    press(4'hB);

    // 1,2,3,4 then '#'
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    hold(4'hB, DEBOUNCE - 1);
    chk("t3_valid_pre", 32'(value_valid), 32'd0);
    tick(1'b1, 4'hB);
    chk("t3_valid", 32'(value_valid), 32'd1);
    chk("t3_value", 32'(value), 32'h1234);
    chk("t3_vcount", 32'(value_count), 32'd4);
    tick(1'b1, 4'hB);
    chk("t3_valid_post", 32'(value_valid), 32'd0);
    chk("t3_buf_clear", 32'(buf_count), 32'd0);
    hold(4'hF, DEBOUNCE);

    // Overflow on a fifth digit
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("t4_ovf_pre", 32'(overflow), 32'd0);
    press(4'h5);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_buf", 32'(buf_digits), 32'h1234);
    press(4'hB);
    chk("t4_value", 32'(value), 32'h1234);
    chk("t4_ovf_clr", 32'(overflow), 32'd0);

    // '*' after 1,2,3
    press(4'h1); press(4'h2); press(4'h3);
    press(4'hA);
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
    chk("t5_buf", 32'(buf_digits), 32'h12);
    chk("t5_count", 32'(buf_count), 32'd2);
`else
    chk("t5_buf", 32'(buf_digits), 32'h0);
    chk("t5_count", 32'(buf_count), 32'd0);
`endif
    press(4'hB);

    // Hold 8, roll to 9 without release
    hold(4'h8, DEBOUNCE + 2);
    hold(4'h9, DEBOUNCE + 3);
    hold(4'hF, DEBOUNCE);
    chk("t6_count", 32'(buf_count), 32'd1);
    chk("t6_digit", 32'(buf_digits), 32'h8);
    chk("t6_press", 32'(press_code), 32'h8);

    // Reset while a key is held; short re-hold must not press
    hold(4'h8, DEBOUNCE + 2);
    pulse_reset();
    hold(4'h8, DEBOUNCE - 1);
    hold(4'hF, DEBOUNCE);
    chk("t6_rst_count", 32'(buf_count), 32'd0);
    chk("t6_rst_press", 32'(press_code), 32'hF);
    press(4'h8);
    chk("t6_repress", 32'(press_code), 32'h8);

    // Randomized key traffic with en gaps, bouncing and invalid codes
    for (int it = 0; it < 400; it++) begin
      logic [3:0] k;
      int n;
      k = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) k = 4'hB;
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) tick(($urandom_range(0, 7) != 0), k);
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, 5);
        for (int j = 0; j < n; j++) tick(($urandom_range(0, 7) != 0), 4'hF);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
